// File: rtl/hazard_scoreboard_if.sv
// Issue/decode-side bundle for hazard_scoreboard.
//   master: the pipeline control (drives issue_*, id_*, flush; observes stall and status)
//   slave : the scoreboard itself
// Signals:
//   issue_valid/issue_regwrite/issue_rd/issue_latency - instruction leaving ID this cycle
//   id_rs/id_rt/id_rs_used/id_rt_used                 - operands of the instruction in ID
//   flush                                             - discard all in-flight writes
//   stall                                             - combinational decode stall
//   pending_mask                                      - one bit per register with cnt != 0
//   stall_count                                       - saturating stall-cycle counter
interface hazard_scoreboard_if #(
  parameter int unsigned NREGS = 32,
  parameter int unsigned AW    = 5,
  parameter int unsigned CW    = 3,
  parameter int unsigned SW    = 16
);
  logic             issue_valid;
  logic             issue_regwrite;
  logic [AW-1:0]    issue_rd;
  logic [CW-1:0]    issue_latency;
  logic [AW-1:0]    id_rs;
  logic [AW-1:0]    id_rt;
  logic             id_rs_used;
  logic             id_rt_used;
  logic             flush;
  logic             stall;
  logic [NREGS-1:0] pending_mask;
  logic [SW-1:0]    stall_count;

  modport master (
    output issue_valid, issue_regwrite, issue_rd, issue_latency,
    output id_rs, id_rt, id_rs_used, id_rt_used, flush,
    input  stall, pending_mask, stall_count
  );

  modport slave (
    input  issue_valid, issue_regwrite, issue_rd, issue_latency,
    input  id_rs, id_rt, id_rs_used, id_rt_used, flush,
    output stall, pending_mask, stall_count
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard for results that are not yet on a forward path (loads, multi-cycle ops).
// Each issued destination gets a countdown of its issue latency; while a register's countdown is
// non-zero, a decode-stage read of it stalls decode. A saturating counter tracks stall cycles.
// Ports:
//   clk     - clock, rising edge
//   reset_n - asynchronous active-low reset
//   bus     - hazard_scoreboard_if slave modport (issue, decode operands, flush, stall, status)
module hazard_scoreboard #(
  parameter int unsigned NREGS = 32,
  parameter int unsigned AW    = 5,   // 2**AW must be >= NREGS
  parameter int unsigned CW    = 3,
  parameter int unsigned SW    = 16
) (
  input logic                 clk,
  input logic                 reset_n,
  hazard_scoreboard_if.slave  bus
);

  localparam int unsigned NIdx = 1 << AW;

  logic [CW-1:0]    cnt_q [NREGS];
  logic [CW-1:0]    cnt_d [NREGS];
  logic [SW-1:0]    stall_count_q, stall_count_d;
  logic [NREGS-1:0] pending;
  logic [NIdx-1:0]  pending_ext;
  logic             rs_hz, rt_hz, stall, issue_fire;

  always_comb begin
    for (int unsigned r = 0; r < NREGS; r++) begin
      pending[r] = (cnt_q[r] != '0);
    end
    // Indices beyond NREGS read as zero, so they never stall.
    pending_ext              = '0;
    pending_ext[NREGS-1:0]   = pending;

    rs_hz = bus.id_rs_used && (bus.id_rs != '0) && pending_ext[bus.id_rs];
    rt_hz = bus.id_rt_used && (bus.id_rt != '0) && pending_ext[bus.id_rt];
    stall = (rs_hz || rt_hz) && !bus.flush;

    issue_fire = bus.issue_valid && !stall && bus.issue_regwrite &&
                 (bus.issue_rd != '0) && !bus.flush;

    for (int unsigned r = 0; r < NREGS; r++) begin
      cnt_d[r] = cnt_q[r];
      if (bus.flush) begin
        cnt_d[r] = '0;
      end else if (issue_fire && (bus.issue_rd == AW'(r))) begin
        // Younger write replaces any older countdown; latency 0 leaves it not pending.
        cnt_d[r] = bus.issue_latency;
      end else if (cnt_q[r] != '0) begin
        cnt_d[r] = cnt_q[r] - CW'(1);
      end
    end

    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned r = 0; r < NREGS; r++) begin
        cnt_q[r] <= '0;
      end
      stall_count_q <= '0;
    end else begin
      for (int unsigned r = 0; r < NREGS; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      stall_count_q <= stall_count_d;
    end
  end

  assign bus.stall        = stall;
  assign bus.pending_mask = pending;
  assign bus.stall_count  = stall_count_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;

  hazard_scoreboard_if #(.NREGS(32), .AW(5), .CW(3), .SW(16)) dif ();
  hazard_scoreboard_if #(.NREGS(32), .AW(5), .CW(3), .SW(4))  sif ();

  hazard_scoreboard #(.NREGS(32), .AW(5), .CW(3), .SW(16)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (dif.slave)
  );

  // Narrow-counter copy sees identical stimulus; used for saturation.
  hazard_scoreboard #(.NREGS(32), .AW(5), .CW(3), .SW(4)) u_dut_sat (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (sif.slave)
  );

  assign sif.issue_valid    = dif.issue_valid;
  assign sif.issue_regwrite = dif.issue_regwrite;
  assign sif.issue_rd       = dif.issue_rd;
  assign sif.issue_latency  = dif.issue_latency;
  assign sif.id_rs          = dif.id_rs;
  assign sif.id_rt          = dif.id_rt;
  assign sif.id_rs_used     = dif.id_rs_used;
  assign sif.id_rt_used     = dif.id_rt_used;
  assign sif.flush          = dif.flush;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        iv;
    logic        rw;
    logic [4:0]  rd;
    logic [2:0]  lat;
    logic [4:0]  rs;
    logic        rsu;
    logic [4:0]  rt;
    logic        rtu;
    logic        fl;
    logic [32:0] exp;   // {stall, pending_mask}
  } row_t;

  logic [32:0] exp_q[$];

  function automatic row_t mk(input int iv, input int rw, input int rd, input int lat,
                              input int rs, input int rsu, input int rt, input int rtu,
                              input int fl, input int es, input logic [31:0] ep);
    row_t r;
    r.iv  = 1'(iv);
    r.rw  = 1'(rw);
    r.rd  = 5'(rd);
    r.lat = 3'(lat);
    r.rs  = 5'(rs);
    r.rsu = 1'(rsu);
    r.rt  = 5'(rt);
    r.rtu = 1'(rtu);
    r.fl  = 1'(fl);
    r.exp = {1'(es), ep};
    return r;
  endfunction

  // Drive one cycle of stimulus just after the edge, queue its expectation, move to mid-cycle.
  task automatic apply(input row_t r);
    dif.issue_valid    = r.iv;
    dif.issue_regwrite = r.rw;
    dif.issue_rd       = r.rd;
    dif.issue_latency  = r.lat;
    dif.id_rs          = r.rs;
    dif.id_rs_used     = r.rsu;
    dif.id_rt          = r.rt;
    dif.id_rt_used     = r.rtu;
    dif.flush          = r.fl;
    exp_q.push_back(r.exp);
    @(negedge clk);
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    dif.issue_valid    = 1'b0;
    dif.issue_regwrite = 1'b0;
    dif.issue_rd       = '0;
    dif.issue_latency  = '0;
    dif.id_rs          = '0;
    dif.id_rs_used     = 1'b0;
    dif.id_rt          = '0;
    dif.id_rt_used     = 1'b0;
    dif.flush          = 1'b0;
  endtask

  task automatic do_reset();
    drive_idle();
    #2 reset_n = 1'b0;
    @(posedge clk);
    #2 reset_n = 1'b1;
    advance();
  endtask

  task automatic test_reset();
    row_t        rows[$];
    logic [32:0] e;
    do_reset();
    rows.push_back(mk(1, 1, 9, 7, 0, 0, 0, 0, 0, 0, 32'h0));
    rows.push_back(mk(0, 0, 0, 0, 9, 1, 0, 0, 0, 1, 32'h200));
    foreach (rows[i]) begin
      apply(rows[i]);
      e = exp_q.pop_front();
      total++;
      if ({dif.stall, dif.pending_mask} !== e || {sif.stall, sif.pending_mask} !== e) begin
        bad++;
        $display("FAIL reset_pre[%0d] stall/pend got %b/%h %b/%h want %b/%h", i, dif.stall,
                 dif.pending_mask, sif.stall, sif.pending_mask, e[32], e[31:0]);
      end
      advance();
    end
    total++;
    if (dif.stall_count !== 16'd1) begin
      bad++;
      $display("FAIL reset_pre_count got %0d want 1", dif.stall_count);
    end
    // Assert reset between edges with rs=9 still being read.
    #2 reset_n = 1'b0;
    #1;
    total++;
    if (dif.stall !== 1'b0 || dif.pending_mask !== 32'h0 || dif.stall_count !== 16'd0 ||
        sif.stall_count !== 4'd0) begin
      bad++;
      $display("FAIL reset_async got stall=%b pend=%h cnt=%0d/%0d want 0/0/0/0", dif.stall,
               dif.pending_mask, dif.stall_count, sif.stall_count);
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      total++;
      if (dif.stall !== 1'b0 || dif.pending_mask !== 32'h0 || dif.stall_count !== 16'd0) begin
        bad++;
        $display("FAIL reset_hold[%0d] got stall=%b pend=%h cnt=%0d want 0/0/0", k, dif.stall,
                 dif.pending_mask, dif.stall_count);
      end
    end
    @(posedge clk);
    #2 reset_n = 1'b1;
    advance();
    rows.delete();
    rows.push_back(mk(0, 0, 0, 0, 9, 1, 0, 0, 0, 0, 32'h0));
    rows.push_back(mk(0, 0, 0, 0, 9, 1, 0, 0, 0, 0, 32'h0));
    foreach (rows[i]) begin
      apply(rows[i]);
      e = exp_q.pop_front();
      total++;
      if ({dif.stall, dif.pending_mask} !== e) begin
        bad++;
        $display("FAIL reset_post[%0d] stall/pend got %b/%h want %b/%h", i, dif.stall,
                 dif.pending_mask, e[32], e[31:0]);
      end
      advance();
    end
    total++;
    if (dif.stall_count !== 16'd0) begin
      bad++;
      $display("FAIL reset_post_count got %0d want 0", dif.stall_count);
    end
  endtask

  task automatic test_load_use();
    row_t        rows[$];
    logic [32:0] e;
    do_reset();
    rows.push_back(mk(1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 32'h0));
    rows.push_back(mk(0, 0, 0, 0, 5, 1, 0, 0, 0, 1, 32'h20));
    rows.push_back(mk(0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 32'h0));
    foreach (rows[i]) begin
      apply(rows[i]);
      e = exp_q.pop_front();
      total++;
      if ({dif.stall, dif.pending_mask} !== e || {sif.stall, sif.pending_mask} !== e) begin
        bad++;
        $display("FAIL load_use[%0d] stall/pend got %b/%h want %b/%h", i, dif.stall,
                 dif.pending_mask, e[32], e[31:0]);
      end
      advance();
    end
    total++;
    if (dif.stall_count !== 16'd1) begin
      bad++;
      $display("FAIL load_use_count got %0d want 1", dif.stall_count);
    end
  endtask

  task automatic test_multi_cycle();
    row_t        rows[$];
    logic [32:0] e;
    do_reset();
    rows.push_back(mk(1, 1, 8, 4, 0, 0, 0, 0, 0, 0, 32'h0));
    for (int k = 0; k < 4; k++) rows.push_back(mk(0, 0, 0, 0, 0, 0, 8, 1, 0, 1, 32'h100));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 8, 1, 0, 0, 32'h0));
    // Same window again, but reading an unrelated register.
    rows.push_back(mk(1, 1, 8, 4, 0, 0, 0, 0, 0, 0, 32'h0));
    for (int k = 0; k < 4; k++) rows.push_back(mk(0, 0, 0, 0, 0, 0, 9, 1, 0, 0, 32'h100));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 9, 1, 0, 0, 32'h0));
    foreach (rows[i]) begin
      apply(rows[i]);
      e = exp_q.pop_front();
      total++;
      if ({dif.stall, dif.pending_mask} !== e) begin
        bad++;
        $display("FAIL multi_cycle[%0d] stall/pend got %b/%h want %b/%h", i, dif.stall,
                 dif.pending_mask, e[32], e[31:0]);
      end
      advance();
    end
    total++;
    if (dif.stall_count !== 16'd4) begin
      bad++;
      $display("FAIL multi_cycle_count got %0d want 4", dif.stall_count);
    end
  endtask

  task automatic test_reg0_unused();
    row_t        rows[$];
    logic [32:0] e;
    do_reset();
    rows.push_back(mk(1, 1, 0, 7, 0, 0, 0, 0, 0, 0, 32'h0));
    rows.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 32'h0));
    rows.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 32'h0));
    rows.push_back(mk(1, 1, 3, 2, 0, 0, 0, 0, 0, 0, 32'h0));
    rows.push_back(mk(0, 0, 0, 0, 3, 0, 3, 0, 0, 0, 32'h8));
    rows.push_back(mk(0, 0, 0, 0, 3, 0, 3, 0, 0, 0, 32'h8));
    rows.push_back(mk(0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 32'h0));
    // Latency 0 (ALU result) and issue without regwrite never mark anything.
    rows.push_back(mk(1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 32'h0));
    rows.push_back(mk(1, 0, 7, 5, 7, 1, 0, 0, 0, 0, 32'h0));
    rows.push_back(mk(0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 32'h0));
    foreach (rows[i]) begin
      apply(rows[i]);
      e = exp_q.pop_front();
      total++;
      if ({dif.stall, dif.pending_mask} !== e) begin
        bad++;
        $display("FAIL reg0_unused[%0d] stall/pend got %b/%h want %b/%h", i, dif.stall,
                 dif.pending_mask, e[32], e[31:0]);
      end
      advance();
    end
    total++;
    if (dif.stall_count !== 16'd0) begin
      bad++;
      $display("FAIL reg0_unused_count got %0d want 0", dif.stall_count);
    end
  endtask

  task automatic test_override_flush();
    row_t        rows[$];
    logic [32:0] e;
    do_reset();
    rows.push_back(mk(1, 1, 4, 5, 0, 0, 0, 0, 0, 0, 32'h0));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h10));
    rows.push_back(mk(1, 1, 4, 1, 0, 0, 0, 0, 0, 0, 32'h10));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h10));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0));
    rows.push_back(mk(1, 1, 6, 6, 0, 0, 0, 0, 0, 0, 32'h0));
    rows.push_back(mk(0, 0, 0, 0, 6, 1, 0, 0, 0, 1, 32'h40));
    rows.push_back(mk(0, 0, 0, 0, 6, 1, 0, 0, 1, 0, 32'h40));
    rows.push_back(mk(0, 0, 0, 0, 6, 1, 0, 0, 0, 0, 32'h0));
    // Flush together with an issue: nothing gets marked.
    rows.push_back(mk(1, 1, 7, 3, 0, 0, 0, 0, 1, 0, 32'h0));
    rows.push_back(mk(0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 32'h0));
    foreach (rows[i]) begin
      apply(rows[i]);
      e = exp_q.pop_front();
      total++;
      if ({dif.stall, dif.pending_mask} !== e) begin
        bad++;
        $display("FAIL override_flush[%0d] stall/pend got %b/%h want %b/%h", i, dif.stall,
                 dif.pending_mask, e[32], e[31:0]);
      end
      advance();
    end
    total++;
    if (dif.stall_count !== 16'd1) begin
      bad++;
      $display("FAIL override_flush_count got %0d want 1", dif.stall_count);
    end
  endtask

  task automatic test_back_to_back();
    row_t        rows[$];
    logic [32:0] e;
    do_reset();
    rows.push_back(mk(1, 1, 10, 2, 0, 0, 0, 0, 0, 0, 32'h0));
    rows.push_back(mk(1, 1, 11, 1, 0, 0, 0, 0, 0, 0, 32'h400));
    // Stalled issue of r12 must be ignored.
    rows.push_back(mk(1, 1, 12, 3, 10, 1, 11, 1, 0, 1, 32'hc00));
    rows.push_back(mk(0, 0, 0, 0, 10, 1, 12, 1, 0, 0, 32'h0));
    foreach (rows[i]) begin
      apply(rows[i]);
      e = exp_q.pop_front();
      total++;
      if ({dif.stall, dif.pending_mask} !== e) begin
        bad++;
        $display("FAIL back_to_back[%0d] stall/pend got %b/%h want %b/%h", i, dif.stall,
                 dif.pending_mask, e[32], e[31:0]);
      end
      advance();
    end
    total++;
    if (dif.stall_count !== 16'd1) begin
      bad++;
      $display("FAIL back_to_back_count got %0d want 1", dif.stall_count);
    end
  endtask

  task automatic test_saturation();
    logic [32:0] e;
    int          exp_cnt;
    do_reset();
    exp_cnt = 0;
    for (int rnd = 0; rnd < 3; rnd++) begin
      apply(mk(1, 1, 2, 7, 2, 1, 0, 0, 0, 0, 32'h0));
      e = exp_q.pop_front();
      total++;
      if ({dif.stall, dif.pending_mask} !== e) begin
        bad++;
        $display("FAIL saturation_issue[%0d] stall/pend got %b/%h want %b/%h", rnd, dif.stall,
                 dif.pending_mask, e[32], e[31:0]);
      end
      advance();
      for (int k = 0; k < 7; k++) begin
        apply(mk(0, 0, 0, 0, 2, 1, 0, 0, 0, 1, 32'h4));
        e = exp_q.pop_front();
        total++;
        if ({sif.stall, sif.pending_mask} !== e) begin
          bad++;
          $display("FAIL saturation_stall[%0d.%0d] stall/pend got %b/%h want %b/%h", rnd, k,
                   sif.stall, sif.pending_mask, e[32], e[31:0]);
        end
        advance();
      end
      exp_cnt += 7;
      total++;
      if (dif.stall_count !== 16'(exp_cnt) ||
          sif.stall_count !== 4'((exp_cnt > 15) ? 15 : exp_cnt)) begin
        bad++;
        $display("FAIL saturation_count[%0d] got %0d/%0d want %0d/%0d", rnd, dif.stall_count,
                 sif.stall_count, exp_cnt, (exp_cnt > 15) ? 15 : exp_cnt);
      end
    end
    drive_idle();
    advance();
    advance();
    total++;
    if (sif.stall_count !== 4'd15 || dif.stall_count !== 16'd21) begin
      bad++;
      $display("FAIL saturation_hold got %0d/%0d want 21/15", dif.stall_count, sif.stall_count);
    end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    reset_n = 1'b0;
    drive_idle();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    advance();
    test_reset();
    test_load_use();
    test_multi_cycle();
    test_reg0_unused();
    test_override_flush();
    test_back_to_back();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
